// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter that shares one memory port between an instruction cache
// and a data cache, with a single outstanding transaction and tag-checked responses.
module mem_arbiter_rr #(
    parameter int ADDR_BITS   = 28,
    parameter int TAG_BITS    = 5,
    parameter int DATA_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 ic_mem_req_valid,
    output logic                 ic_mem_req_ready,
    input  logic [ADDR_BITS-1:0] ic_mem_req_addr,
    output logic                 ic_mem_resp_valid,

    input  logic                 dc_mem_req_valid,
    output logic                 dc_mem_req_ready,
    input  logic                 dc_mem_req_rw,
    input  logic [ADDR_BITS-1:0] dc_mem_req_addr,
    input  logic                 dc_mem_req_data_valid,
    output logic                 dc_mem_req_data_ready,
    output logic                 dc_mem_resp_valid,

    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic                 mem_req_rw,
    output logic [ADDR_BITS-1:0] mem_req_addr,
    output logic [TAG_BITS-1:0]  mem_req_tag,
    output logic                 mem_req_data_valid,
    input  logic                 mem_req_data_ready,
    input  logic                 mem_resp_valid,
    input  logic [TAG_BITS-1:0]  mem_resp_tag,

    output logic                 tag_error
);

    localparam int CNT_BITS = (DATA_CYCLES > 1) ? $clog2(DATA_CYCLES) : 1;
    localparam int SEQ_BITS = TAG_BITS - 1;
    localparam logic [CNT_BITS-1:0] LAST_BEAT = CNT_BITS'(DATA_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WDATA,
        S_RESP
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_grant_dc;
    logic                  r_last_dc;
    logic                  r_rw;
    logic                  r_tag_error;
    logic [ADDR_BITS-1:0]  r_addr;
    logic [TAG_BITS-1:0]   r_tag;
    logic [SEQ_BITS-1:0]   r_seq;
    logic [CNT_BITS-1:0]   r_cnt;

    logic w_run;
    logic w_grant;
    logic w_grant_dc;
    logic w_req_hs;
    logic w_wbeat;
    logic w_rbeat;
    logic w_bad_resp;

    // Every handshake output is forced low while reset is held, whatever the state.
    assign w_run = reset;

    assign mem_req_addr = r_addr;
    assign mem_req_rw   = r_rw;
    assign mem_req_tag  = r_tag;
    assign tag_error    = r_tag_error;

    always_comb begin
        // NOTE: every signal gets a default first, so no branch can infer a latch.
        w_state_nxt           = r_state;
        w_grant               = 1'b0;
        w_grant_dc            = 1'b0;
        w_req_hs              = 1'b0;
        w_wbeat               = 1'b0;
        w_rbeat               = 1'b0;
        ic_mem_req_ready      = 1'b0;
        dc_mem_req_ready      = 1'b0;
        ic_mem_resp_valid     = 1'b0;
        dc_mem_resp_valid     = 1'b0;
        dc_mem_req_data_ready = 1'b0;
        mem_req_valid         = 1'b0;
        mem_req_data_valid    = 1'b0;

        if (w_run) begin
            case (r_state)
                S_IDLE: begin
                    if (ic_mem_req_valid || dc_mem_req_valid) begin
                        w_grant     = 1'b1;
                        // On a tie the side that did not win last time goes first.
                        w_grant_dc  = dc_mem_req_valid && (!ic_mem_req_valid || !r_last_dc);
                        w_state_nxt = S_REQ;
                    end
                end
                S_REQ: begin
                    mem_req_valid    = 1'b1;
                    ic_mem_req_ready = mem_req_ready && !r_grant_dc;
                    dc_mem_req_ready = mem_req_ready &&  r_grant_dc;
                    if (mem_req_ready) begin
                        w_req_hs    = 1'b1;
                        w_state_nxt = r_rw ? S_WDATA : S_RESP;
                    end
                end
                S_WDATA: begin
                    mem_req_data_valid    = dc_mem_req_data_valid;
                    dc_mem_req_data_ready = mem_req_data_ready;
                    w_wbeat               = dc_mem_req_data_valid && mem_req_data_ready;
                    if (w_wbeat && (r_cnt == LAST_BEAT)) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_RESP: begin
                    w_rbeat           = mem_resp_valid && (mem_resp_tag == r_tag);
                    ic_mem_resp_valid = w_rbeat && !r_grant_dc;
                    dc_mem_resp_valid = w_rbeat &&  r_grant_dc;
                    if (w_rbeat && (r_cnt == LAST_BEAT)) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Any response that is not a forwarded beat is stale or mis-tagged.
    assign w_bad_resp = mem_resp_valid && !w_rbeat;

    // NOTE: reset is sampled on the clock edge only; it is not in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_grant_dc  <= 1'b0;
            r_last_dc   <= 1'b1;
            r_rw        <= 1'b0;
            r_addr      <= '0;
            r_tag       <= '0;
            r_seq       <= '0;
            r_cnt       <= '0;
            r_tag_error <= 1'b0;
        end else begin
            if (w_grant) begin
                r_grant_dc <= w_grant_dc;
                r_rw       <= w_grant_dc && dc_mem_req_rw;
                r_addr     <= w_grant_dc ? dc_mem_req_addr : ic_mem_req_addr;
                r_tag      <= {r_seq, w_grant_dc};
            end
            if (w_req_hs) begin
                r_cnt     <= '0;
                r_seq     <= r_seq + 1'b1;
                r_last_dc <= r_grant_dc;
            end else if (w_wbeat || w_rbeat) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_bad_resp) begin
                r_tag_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Scoreboard bench for mem_arbiter_rr: a transaction-level model predicts grant
// order, tags and beat counts; a negedge monitor pops and compares DUT activity.
`timescale 1ns/1ps
module tb_mem_arbiter_rr;

    localparam int ADDR_BITS    = 28;
    localparam int TAG_BITS     = 5;
    localparam int DATA_CYCLES  = 4;
    localparam int SEQ_MOD      = 1 << (TAG_BITS - 1);
    localparam int ROUND_BUDGET = 400;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 ic_mem_req_valid;
    logic                 ic_mem_req_ready;
    logic [ADDR_BITS-1:0] ic_mem_req_addr;
    logic                 ic_mem_resp_valid;
    logic                 dc_mem_req_valid;
    logic                 dc_mem_req_ready;
    logic                 dc_mem_req_rw;
    logic [ADDR_BITS-1:0] dc_mem_req_addr;
    logic                 dc_mem_req_data_valid;
    logic                 dc_mem_req_data_ready;
    logic                 dc_mem_resp_valid;
    logic                 mem_req_valid;
    logic                 mem_req_ready;
    logic                 mem_req_rw;
    logic [ADDR_BITS-1:0] mem_req_addr;
    logic [TAG_BITS-1:0]  mem_req_tag;
    logic                 mem_req_data_valid;
    logic                 mem_req_data_ready;
    logic                 mem_resp_valid;
    logic [TAG_BITS-1:0]  mem_resp_tag;
    logic                 tag_error;

    always #5 clk = ~clk;

    mem_arbiter_rr #(
        .ADDR_BITS  (ADDR_BITS),
        .TAG_BITS   (TAG_BITS),
        .DATA_CYCLES(DATA_CYCLES)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .ic_mem_req_valid     (ic_mem_req_valid),
        .ic_mem_req_ready     (ic_mem_req_ready),
        .ic_mem_req_addr      (ic_mem_req_addr),
        .ic_mem_resp_valid    (ic_mem_resp_valid),
        .dc_mem_req_valid     (dc_mem_req_valid),
        .dc_mem_req_ready     (dc_mem_req_ready),
        .dc_mem_req_rw        (dc_mem_req_rw),
        .dc_mem_req_addr      (dc_mem_req_addr),
        .dc_mem_req_data_valid(dc_mem_req_data_valid),
        .dc_mem_req_data_ready(dc_mem_req_data_ready),
        .dc_mem_resp_valid    (dc_mem_resp_valid),
        .mem_req_valid        (mem_req_valid),
        .mem_req_ready        (mem_req_ready),
        .mem_req_rw           (mem_req_rw),
        .mem_req_addr         (mem_req_addr),
        .mem_req_tag          (mem_req_tag),
        .mem_req_data_valid   (mem_req_data_valid),
        .mem_req_data_ready   (mem_req_data_ready),
        .mem_resp_valid       (mem_resp_valid),
        .mem_resp_tag         (mem_resp_tag),
        .tag_error            (tag_error)
    );

    typedef struct {
        logic [ADDR_BITS-1:0] addr;
        logic                 rw;
        logic [TAG_BITS-1:0]  tag;
    } exp_req_t;

    exp_req_t            exp_req_q[$];
    logic [TAG_BITS-1:0] exp_ic_q[$];
    logic [TAG_BITS-1:0] exp_dc_q[$];
    int                  exp_wbeat_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int model_seq;
    bit model_last_dc;
    bit exp_tag_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one grant -> one request, then its data or response beats.
    task automatic model_issue(input bit is_dc, input logic [ADDR_BITS-1:0] addr, input bit rw);
        exp_req_t e;
        e.addr = addr;
        e.rw   = rw;
        e.tag  = TAG_BITS'((model_seq << 1) | int'(is_dc));
        exp_req_q.push_back(e);
        for (int i = 0; i < DATA_CYCLES; i++) begin
            if (rw)         exp_wbeat_q.push_back(i);
            else if (is_dc) exp_dc_q.push_back(e.tag);
            else            exp_ic_q.push_back(e.tag);
        end
        model_seq     = (model_seq + 1) % SEQ_MOD;
        model_last_dc = is_dc;
    endtask

    always @(negedge clk) begin : monitor
        exp_req_t e;
        if (reset === 1'b1) begin
            if (mem_req_valid && mem_req_ready) begin
                check("req_expected", 64'(exp_req_q.size() != 0), 1);
                if (exp_req_q.size() != 0) begin
                    e = exp_req_q.pop_front();
                    check("req_addr", 64'(mem_req_addr), 64'(e.addr));
                    check("req_rw", 64'(mem_req_rw), 64'(e.rw));
                    check("req_tag", 64'(mem_req_tag), 64'(e.tag));
                end
            end
            if (ic_mem_resp_valid) begin
                check("ic_beat_expected", 64'(exp_ic_q.size() != 0), 1);
                if (exp_ic_q.size() != 0) check("ic_beat_tag", 64'(mem_resp_tag), 64'(exp_ic_q.pop_front()));
            end
            if (dc_mem_resp_valid) begin
                check("dc_beat_expected", 64'(exp_dc_q.size() != 0), 1);
                if (exp_dc_q.size() != 0) check("dc_beat_tag", 64'(mem_resp_tag), 64'(exp_dc_q.pop_front()));
            end
            if (mem_req_data_valid && mem_req_data_ready) begin
                check("wbeat_expected", 64'(exp_wbeat_q.size() != 0), 1);
                if (exp_wbeat_q.size() != 0) void'(exp_wbeat_q.pop_front());
            end
        end
    end

    function automatic logic [6:0] handshake_outs();
        return {ic_mem_req_ready, ic_mem_resp_valid, dc_mem_req_ready, dc_mem_req_data_ready,
                dc_mem_resp_valid, mem_req_valid, mem_req_data_valid};
    endfunction

    task automatic idle_inputs();
        ic_mem_req_valid      = 1'b0;
        dc_mem_req_valid      = 1'b0;
        dc_mem_req_rw         = 1'b0;
        dc_mem_req_data_valid = 1'b0;
        mem_req_ready         = 1'b0;
        mem_req_data_ready    = 1'b0;
        mem_resp_valid        = 1'b0;
        mem_resp_tag          = '0;
    endtask

    task automatic clear_model();
        exp_req_q.delete();
        exp_ic_q.delete();
        exp_dc_q.delete();
        exp_wbeat_q.delete();
        model_seq     = 0;
        model_last_dc = 1'b1;
        exp_tag_err   = 1'b0;
    endtask

    // Entered and left just after a rising edge.
    task automatic apply_reset();
        reset = 1'b0;
        idle_inputs();
        repeat (2) begin
            @(negedge clk);
            check("rst_outputs", 64'(handshake_outs()), 0);
            @(posedge clk); #1;
        end
        check("rst_tag_error", 64'(tag_error), 0);
        clear_model();
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_outputs", 64'(handshake_outs()), 0);
        @(posedge clk); #1;
    endtask

    task automatic run_round(input bit want_ic, input bit want_dc, input bit dc_rw);
        logic [ADDR_BITS-1:0] ic_addr;
        logic [ADDR_BITS-1:0] dc_addr;
        logic [TAG_BITS-1:0]  rd_tag;
        bit ic_pend;
        bit dc_pend;
        bit bad;
        int rd_left;
        int wr_left;
        int cycles;
        int r;
        ic_addr = ADDR_BITS'($urandom);
        dc_addr = ADDR_BITS'($urandom);
        ic_pend = want_ic;
        dc_pend = want_dc;
        rd_tag  = '0;
        rd_left = 0;
        wr_left = 0;
        cycles  = 0;
        if (want_ic && want_dc) begin
            if (model_last_dc) begin
                model_issue(1'b0, ic_addr, 1'b0);
                model_issue(1'b1, dc_addr, dc_rw);
            end else begin
                model_issue(1'b1, dc_addr, dc_rw);
                model_issue(1'b0, ic_addr, 1'b0);
            end
        end else if (want_ic) begin
            model_issue(1'b0, ic_addr, 1'b0);
        end else if (want_dc) begin
            model_issue(1'b1, dc_addr, dc_rw);
        end
        ic_mem_req_addr  = ic_addr;
        dc_mem_req_addr  = dc_addr;
        dc_mem_req_rw    = dc_rw;
        ic_mem_req_valid = want_ic;
        dc_mem_req_valid = want_dc;
        while ((ic_pend || dc_pend || rd_left > 0 || wr_left > 0) && cycles < ROUND_BUDGET) begin
            mem_req_ready         = ($urandom_range(0, 3) != 0);
            mem_req_data_ready    = 1'($urandom_range(0, 1));
            dc_mem_req_data_valid = 1'($urandom_range(0, 1));
            mem_resp_valid        = 1'b0;
            mem_resp_tag          = '0;
            bad                   = 1'b0;
            if (rd_left > 0) begin
                r = $urandom_range(0, 9);
                if (r < 6) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_tag   = rd_tag;
                end else if (r == 6) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_tag   = rd_tag ^ {1'b1, {(TAG_BITS-1){1'b0}}};
                    bad            = 1'b1;
                    exp_tag_err    = 1'b1;
                end
            end
            @(negedge clk);
            if (mem_resp_valid && !bad && rd_left > 0) rd_left--;
            if (dc_mem_req_data_valid && dc_mem_req_data_ready && wr_left > 0) wr_left--;
            if (mem_req_valid && mem_req_ready) begin
                if (mem_req_rw) begin
                    wr_left = DATA_CYCLES;
                end else begin
                    rd_left = DATA_CYCLES;
                    rd_tag  = mem_req_tag;
                end
            end
            if (ic_mem_req_ready) ic_pend = 1'b0;
            if (dc_mem_req_ready) dc_pend = 1'b0;
            @(posedge clk); #1;
            ic_mem_req_valid = ic_pend;
            dc_mem_req_valid = dc_pend;
            cycles++;
        end
        idle_inputs();
        check("round_in_budget", 64'(cycles < ROUND_BUDGET), 1);
        check("tag_error", 64'(tag_error), 64'(exp_tag_err));
        check("req_q_drained", 64'(exp_req_q.size()), 0);
        check("ic_beats_drained", 64'(exp_ic_q.size()), 0);
        check("dc_beats_drained", 64'(exp_dc_q.size()), 0);
        check("wbeats_drained", 64'(exp_wbeat_q.size()), 0);
        if (cycles >= ROUND_BUDGET) apply_reset();
    endtask

    // Idle cycles, occasionally with a stray response that must raise tag_error.
    task automatic idle_gap();
        int n;
        n = $urandom_range(0, 2);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                mem_resp_valid = 1'b1;
                mem_resp_tag   = TAG_BITS'($urandom);
                exp_tag_err    = 1'b1;
            end
            @(posedge clk); #1;
            mem_resp_valid = 1'b0;
        end
    endtask

    task automatic reset_mid_wdata();
        logic [ADDR_BITS-1:0] a;
        int beats;
        int cycles;
        a      = ADDR_BITS'($urandom);
        beats  = 0;
        cycles = 0;
        model_issue(1'b1, a, 1'b1);
        dc_mem_req_addr       = a;
        dc_mem_req_rw         = 1'b1;
        dc_mem_req_valid      = 1'b1;
        mem_req_ready         = 1'b1;
        dc_mem_req_data_valid = 1'b1;
        mem_req_data_ready    = 1'b1;
        while (beats < 2 && cycles < 50) begin
            @(negedge clk);
            if (dc_mem_req_data_ready) beats++;
            @(posedge clk); #1;
            if (!dc_mem_req_ready && dc_mem_req_valid && cycles > 0) dc_mem_req_valid = 1'b0;
            cycles++;
        end
        dc_mem_req_valid = 1'b0;
        check("mid_wdata_beats", 64'(beats), 2);
        check("mid_wdata_left", 64'(exp_wbeat_q.size()), 2);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_outputs", 64'(handshake_outs()), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        idle_inputs();
        clear_model();
        @(negedge clk);
        check("after_mid_rst_outputs", 64'(handshake_outs()), 0);
        check("after_mid_rst_tag_error", 64'(tag_error), 0);
        @(posedge clk); #1;
        run_round(1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        int sel;
        reset           = 1'b0;
        ic_mem_req_addr = '0;
        dc_mem_req_addr = '0;
        idle_inputs();
        clear_model();
        @(posedge clk); #1;
        apply_reset();

        run_round(1'b1, 1'b0, 1'b0);
        apply_reset();
        run_round(1'b1, 1'b1, 1'b0);
        apply_reset();
        for (int i = 0; i < 17; i++) run_round(1'b1, 1'b0, 1'b0);
        run_round(1'b0, 1'b1, 1'b1);

        for (int i = 0; i < 60; i++) begin
            sel = $urandom_range(1, 3);
            run_round(sel[0], sel[1], 1'($urandom_range(0, 1)));
            idle_gap();
        end
        check("tag_error_sticky", 64'(tag_error), 64'(exp_tag_err));

        apply_reset();
        reset_mid_wdata();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter_rr.md
MEM_ARBITER_RR -- requirements
Module: mem_arbiter_rr

Interface
REQ-001 Parameters SHALL be: ADDR_BITS, default 28, memory line address width; TAG_BITS, default 5, memory tag width; DATA_CYCLES, default 4, beats per line.
REQ-002 Port clk SHALL be: input, 1 bit, the only clock; all state updates on its rising edge.
REQ-003 Port reset SHALL be: input, 1 bit, synchronous, active-low (0 = reset).
REQ-004 Instruction-cache request ports SHALL be: ic_mem_req_valid in 1; ic_mem_req_ready out 1; ic_mem_req_addr in ADDR_BITS; ic_mem_resp_valid out 1.
REQ-005 Data-cache request ports SHALL be: dc_mem_req_valid in 1; dc_mem_req_ready out 1; dc_mem_req_rw in 1 (1 = write); dc_mem_req_addr in ADDR_BITS.
REQ-006 Data-cache write-data and response ports SHALL be: dc_mem_req_data_valid in 1; dc_mem_req_data_ready out 1; dc_mem_resp_valid out 1.
REQ-007 Memory request ports SHALL be: mem_req_valid out 1; mem_req_ready in 1; mem_req_rw out 1; mem_req_addr out ADDR_BITS; mem_req_tag out TAG_BITS.
REQ-008 Memory data and response ports SHALL be: mem_req_data_valid out 1; mem_req_data_ready in 1; mem_resp_valid in 1; mem_resp_tag in TAG_BITS.
REQ-009 Port tag_error SHALL be: output, 1 bit, sticky flag for an unexpected response.
REQ-010 Write-data and response-data buses SHALL NOT pass through this block; it gates their valid/ready only.

Function
REQ-011 The FSM SHALL have four states: IDLE, REQ, WDATA and RESP. At most one memory transaction SHALL be outstanding.
REQ-012 IDLE: when any requester is valid, the FSM SHALL latch grant, addr, rw (rw = 0 for the icache) and tag, then enter REQ on the next cycle.
REQ-013 Simultaneous requests in IDLE SHALL be granted to the requester that was not granted last. After reset, the icache SHALL win the first tie.
REQ-014 REQ: mem_req_valid SHALL be 1, with mem_req_addr, mem_req_rw and mem_req_tag driven from the latched registers, held stable until mem_req_ready.
REQ-015 The granted requester's *_mem_req_ready SHALL equal mem_req_ready & (state==REQ). The non-granted requester's ready SHALL be 0.
REQ-016 On the REQ handshake, the FSM SHALL go to WDATA if rw = 1, else to RESP. The beat counter SHALL clear.
REQ-017 Tag SHALL be {seq[TAG_BITS-2:0], grant_is_dc}. seq SHALL increment on every REQ handshake and wrap from all-ones to 0.
REQ-018 WDATA: mem_req_data_valid SHALL equal dc_mem_req_data_valid, and dc_mem_req_data_ready SHALL equal mem_req_data_ready. Both SHALL be 0 in every other state.
REQ-019 WDATA: the counter SHALL increment on each valid&ready beat. After beat DATA_CYCLES the FSM SHALL enter IDLE; no write response is expected.
REQ-020 RESP: the granted requester's *_mem_resp_valid SHALL equal mem_resp_valid & (mem_resp_tag == latched tag), combinationally. The other requester's resp_valid SHALL be 0.
REQ-021 RESP: each matching beat SHALL increment the counter. After the DATA_CYCLES-th beat the FSM SHALL enter IDLE on the next cycle.
REQ-022 A mem_resp_valid with a non-matching tag, or any mem_resp_valid outside RESP, SHALL be dropped (never forwarded) and SHALL set tag_error until reset.
REQ-023 The last-grant pointer SHALL update at each REQ handshake.
REQ-024 A requester dropping valid while in REQ (protocol violation) SHALL NOT abort the transaction.
REQ-025 Minimum read occupancy SHALL be: grant cycle + REQ cycle + DATA_CYCLES response beats; IDLE is re-entered one cycle after the last beat.

Reset
REQ-026 While reset = 0 at a clock edge: state SHALL be IDLE; counter, seq and tag_error SHALL be 0; the pointer SHALL make the icache win the next tie.
REQ-027 During and after reset, all valid/ready outputs SHALL be 0 until a new grant. An in-flight transaction SHALL be abandoned, and stale responses after reset SHALL set tag_error.

Verification
REQ-028 Scenario: ic read alone, mem_req_ready = 1, 4 response beats with tag 0x00 -> mem_req_valid 1 cycle, addr = ic addr, rw = 0, tag = 0x00; ic_mem_resp_valid = 1 on exactly 4 beats; dc_mem_resp_valid stays 0.
REQ-029 Scenario: ic and dc valid on the same cycle after reset -> ic granted first (tag 0x00); dc granted after ic's 4th beat (tag 0x03).
REQ-030 Scenario: dc write with mem_req_data_ready toggling 1,0,1,0,1,0,1 -> exactly 4 data beats pass, then IDLE; dc_mem_resp_valid never asserts.
REQ-031 Scenario: during ic RESP, inject a beat with a wrong tag -> not forwarded, beat count unchanged, tag_error = 1 and sticky; 4 correct beats then complete.
REQ-032 Scenario: 17 consecutive ic reads -> seq wraps after 0x1E (seq 15) to tag 0x00 on the 17th.
REQ-033 Scenario: reset = 0 asserted mid-WDATA after 2 beats -> next cycle state IDLE, all outputs 0; a new dc request receives tag 0x01.
